dataproc_iomem: RTL and testbench



---
 rtl/dataproc_pkg.sv | 38 +++
 rtl/dataproc_fifo.sv | 55 +++++
 rtl/dataproc_iomem.sv | 176 +++++++++++++++++
 tb/tb_dataproc_iomem.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataproc_pkg.sv
// Shared definitions for the dataproc iomem peripheral:
// register map, mode encodings, status bit positions.
package dataproc_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DIN    = 8'h08;
    localparam logic [7:0] OFF_DOUT   = 8'h0C;
    localparam logic [7:0] OFF_THRESH = 8'h10;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_ACCUM  = 2'd3
    } mode_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CLEAR = 3;

    localparam int ST_IN_EMPTY  = 0;
    localparam int ST_IN_FULL   = 1;
    localparam int ST_OUT_EMPTY = 2;
    localparam int ST_OUT_FULL  = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_UDF       = 5;
    localparam int ST_IN_CNT    = 8;
    localparam int ST_OUT_CNT   = 16;

    localparam logic [7:0] THRESH_RST = 8'h80;

    function automatic logic [7:0] sat_add(logic [7:0] a, logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/dataproc_fifo.sv
// Synchronous 8-bit FIFO with flush; push to full and pop from
// empty are ignored, flush wins over both.
module dataproc_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [CW-2:0] wr_ptr;
    logic [CW-2:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dataproc_iomem.sv
// Memory-mapped byte-stream processor: in-FIFO -> 2-stage
// transform pipeline -> out-FIFO, accessed over the iomem bus.
module dataproc_iomem
    import dataproc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [7:0]  iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready
);

    logic          fire, wr, rd;
    logic [7:0]    off;
    logic          hit_ctrl, hit_status, hit_din, hit_dout, hit_thresh;
    logic          en;
    mode_e         mode;
    logic [7:0]    thresh;
    logic          ovf, udf;
    logic          clear;
    logic          din_push, dout_pop, pipe_pop;
    logic [7:0]    in_dout, out_dout;
    logic [CW-1:0] in_count, out_count;
    logic          in_full, in_empty, out_full, out_empty;
    logic          s1_v, s2_v;
    logic [7:0]    s1_d, s2_d, acc, acc_next, result;
    logic [CW:0]   used;
    logic [31:0]   status, rd_word;
    logic          unused_bits;

    assign fire = iomem_valid & ~iomem_ready;
    assign wr   = fire & (|iomem_wstrb);
    assign rd   = fire & ~(|iomem_wstrb);
    assign off  = {iomem_addr[7:2], 2'b00};

    assign hit_ctrl   = (off == OFF_CTRL);
    assign hit_status = (off == OFF_STATUS);
    assign hit_din    = (off == OFF_DIN);
    assign hit_dout   = (off == OFF_DOUT);
    assign hit_thresh = (off == OFF_THRESH);

    assign unused_bits = ^{iomem_wdata[31:8], iomem_addr[1:0]};

    assign clear    = wr & hit_ctrl & iomem_wdata[CTRL_CLEAR];
    assign din_push = wr & hit_din & ~in_full;
    assign dout_pop = rd & hit_dout & ~out_empty;

    // Reserve out-FIFO space for bytes still in flight
    assign used = {1'b0, out_count}
                + {{CW{1'b0}}, s1_v}
                + {{CW{1'b0}}, s2_v};
    assign pipe_pop = en & ~in_empty & (used < (CW+1)'(DEPTH));

    dataproc_fifo #(.DEPTH(DEPTH), .CW(CW)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (din_push),
        .pop   (pipe_pop),
        .flush (clear),
        .din   (iomem_wdata[7:0]),
        .dout  (in_dout),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    dataproc_fifo #(.DEPTH(DEPTH), .CW(CW)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s2_v),
        .pop   (dout_pop),
        .flush (clear),
        .din   (s2_d),
        .dout  (out_dout),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    assign acc_next = sat_add(acc, s1_d);

    always_comb begin
        result = s1_d;
        unique case (mode)
            MODE_BYPASS: result = s1_d;
            MODE_INVERT: result = ~s1_d;
            MODE_THRESH: result = (s1_d >= thresh) ? 8'hFF : 8'h00;
            MODE_ACCUM:  result = acc_next;
            default:     result = s1_d;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v <= 1'b0;
            s1_d <= '0;
            s2_v <= 1'b0;
            s2_d <= '0;
            acc  <= '0;
        end else if (clear) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            acc  <= '0;
        end else begin
            s1_v <= pipe_pop;
            s1_d <= in_dout;
            s2_v <= s1_v;
            if (s1_v) s2_d <= result;
            if (s1_v && mode == MODE_ACCUM) acc <= acc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en     <= 1'b0;
            mode   <= MODE_BYPASS;
            thresh <= THRESH_RST;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr && hit_ctrl) begin
                en   <= iomem_wdata[CTRL_EN];
                mode <= mode_e'(iomem_wdata[2:1]);
            end
            if (wr && hit_thresh) thresh <= iomem_wdata[7:0];
            if (wr && hit_din && in_full)
                ovf <= 1'b1;
            else if (wr && hit_status && iomem_wdata[ST_OVF])
                ovf <= 1'b0;
            if (rd && hit_dout && out_empty)
                udf <= 1'b1;
            else if (wr && hit_status && iomem_wdata[ST_UDF])
                udf <= 1'b0;
        end
    end

    always_comb begin
        status                   = '0;
        status[ST_IN_EMPTY]      = in_empty;
        status[ST_IN_FULL]       = in_full;
        status[ST_OUT_EMPTY]     = out_empty;
        status[ST_OUT_FULL]      = out_full;
        status[ST_OVF]           = ovf;
        status[ST_UDF]           = udf;
        status[ST_IN_CNT +: CW]  = in_count;
        status[ST_OUT_CNT +: CW] = out_count;
    end

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            hit_ctrl:   rd_word = {28'b0, 1'b0, mode, en};
            hit_status: rd_word = status;
            hit_thresh: rd_word = {24'b0, thresh};
            hit_dout:   rd_word = out_empty ? 32'b0 : {24'b0, out_dout};
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= fire;
            iomem_rdata <= rd ? rd_word : 32'b0;
        end
    end

endmodule

// File: tb/tb_dataproc_iomem.sv
// Bench for dataproc_iomem: directed scenarios plus random bus
// traffic checked against a queue-based behavioural model.
module tb_dataproc_iomem;
    import dataproc_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  wstrb;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    logic       m_en;
    logic [1:0] m_mode;
    logic [7:0] m_thresh;
    int         m_acc;
    logic       m_ovf, m_udf;

    always #5 clk = ~clk;

    dataproc_iomem #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (valid),
        .iomem_wstrb (wstrb),
        .iomem_addr  (addr),
        .iomem_wdata (wdata),
        .iomem_rdata (rdata),
        .iomem_ready (ready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model_reset();
        in_q.delete();
        out_q.delete();
        m_en = 0; m_mode = 0; m_thresh = 8'h80;
        m_acc = 0; m_ovf = 0; m_udf = 0;
    endfunction

    function automatic logic [7:0] xform(logic [7:0] d);
        case (m_mode)
            2'd0: return d;
            2'd1: return 8'hFF - d;
            2'd2: return (d >= m_thresh) ? 8'hFF : 8'h00;
            default: begin
                m_acc = m_acc + int'(d);
                if (m_acc > 255) m_acc = 255;
                return m_acc[7:0];
            end
        endcase
    endfunction

    function automatic void settle();
        while (m_en && in_q.size() > 0 && out_q.size() < DEPTH)
            out_q.push_back(xform(in_q.pop_front()));
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s = 0;
        s[0] = (in_q.size() == 0);
        s[1] = (in_q.size() == DEPTH);
        s[2] = (out_q.size() == 0);
        s[3] = (out_q.size() == DEPTH);
        s[4] = m_ovf;
        s[5] = m_udf;
        s[15:8]  = 8'(in_q.size());
        s[23:16] = 8'(out_q.size());
        return s;
    endfunction

    function automatic logic [31:0] model_access(logic [7:0] a,
            logic [3:0] ws, logic [31:0] wd);
        logic [31:0] r = 0;
        logic [7:0]  o = {a[7:2], 2'b00};
        if (ws != 0) begin
            if (o == OFF_CTRL) begin
                m_en = wd[0];
                m_mode = wd[2:1];
                if (wd[3]) begin
                    in_q.delete(); out_q.delete(); m_acc = 0;
                end
            end else if (o == OFF_STATUS) begin
                if (wd[4]) m_ovf = 0;
                if (wd[5]) m_udf = 0;
            end else if (o == OFF_DIN) begin
                if (in_q.size() == DEPTH) m_ovf = 1;
                else in_q.push_back(wd[7:0]);
            end else if (o == OFF_THRESH) begin
                m_thresh = wd[7:0];
            end
        end else begin
            if (o == OFF_CTRL) r = {29'b0, m_mode, m_en};
            else if (o == OFF_STATUS) r = model_status();
            else if (o == OFF_THRESH) r = {24'b0, m_thresh};
            else if (o == OFF_DOUT) begin
                if (out_q.size() > 0) r = {24'b0, out_q.pop_front()};
                else m_udf = 1;
            end
        end
        settle();
        return r;
    endfunction

    // One bus transaction; valid is held one extra cycle to see ready drop
    task automatic bus(input logic [7:0] a, input logic [3:0] ws,
                       input logic [31:0] wd, output logic [31:0] r);
        bit done = 0;
        @(negedge clk);
        valid = 1; addr = a; wstrb = ws; wdata = wd;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clk); #1;
            done = ready;
        end
        check("handshake", 32'(done), 32'd1);
        r = rdata;
        @(posedge clk); #1;
        check("ready_pulse", 32'(ready), 32'd0);
        valid = 0;
    endtask

    task automatic op(input logic [7:0] a, input logic [3:0] ws,
                      input logic [31:0] wd, output logic [31:0] r);
        logic [31:0] exp;
        exp = model_access(a, ws, wd);
        bus(a, ws, wd, r);
        if (ws == 0) check($sformatf("rd@%02h", a), r, exp);
        repeat (DEPTH + 8) @(posedge clk);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        op(a, 4'hF, d, r);
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] r);
        op(a, 4'h0, 32'h0, r);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  a;
        int          k;
        reset = 1; valid = 0; wstrb = 0; addr = 0; wdata = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 0;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'd0);

        bus_rd(OFF_STATUS, r); check("t1_status", r, 32'h5);
        bus_rd(OFF_THRESH, r); check("t1_thresh", r, 32'h80);

        // Exact latency: out_count rises three edges after the push
        bus_wr(OFF_CTRL, 32'h1);
        void'(model_access(OFF_DIN, 4'hF, 32'h5A));
        bus(OFF_DIN, 4'hF, 32'h5A, r);
        bus(OFF_STATUS, 4'h0, 0, r); check("lat_n2", r, 32'h5);
        bus(OFF_STATUS, 4'h0, 0, r); check("lat_n4", r, 32'h0001_0001);
        repeat (DEPTH + 8) @(posedge clk);
        bus_rd(OFF_DOUT, r); check("lat_data", r, 32'h5A);

        // Bypass and underflow
        bus_wr(OFF_DIN, 32'h12);
        bus_wr(OFF_DIN, 32'h34);
        bus_wr(OFF_DIN, 32'hAB);
        bus_rd(OFF_DOUT, r); check("t2_d0", r, 32'h12);
        bus_rd(OFF_DOUT, r); check("t2_d1", r, 32'h34);
        bus_rd(OFF_DOUT, r); check("t2_d2", r, 32'hAB);
        bus_rd(OFF_DOUT, r); check("t2_empty", r, 32'h0);
        bus_rd(OFF_STATUS, r); check("t2_udf", 32'(r[5]), 32'd1);
        bus_wr(OFF_STATUS, 32'h20);
        bus_rd(OFF_STATUS, r); check("t2_udf_clr", 32'(r[5]), 32'd0);

        // Threshold and invert
        bus_wr(OFF_CTRL, 32'h5);
        bus_wr(OFF_THRESH, 32'h40);
        bus_wr(OFF_DIN, 32'h3F);
        bus_wr(OFF_DIN, 32'h40);
        bus_wr(OFF_DIN, 32'hFF);
        bus_rd(OFF_DOUT, r); check("t3_lo", r, 32'h00);
        bus_rd(OFF_DOUT, r); check("t3_eq", r, 32'hFF);
        bus_rd(OFF_DOUT, r); check("t3_hi", r, 32'hFF);
        bus_wr(OFF_CTRL, 32'h3);
        bus_wr(OFF_DIN, 32'h0F);
        bus_rd(OFF_DOUT, r); check("t3_inv", r, 32'hF0);

        // Saturating accumulate, then CLEAR resets acc
        bus_wr(OFF_CTRL, 32'hF);
        bus_wr(OFF_DIN, 32'h80);
        bus_wr(OFF_DIN, 32'h70);
        bus_wr(OFF_DIN, 32'h20);
        bus_rd(OFF_DOUT, r); check("t4_a0", r, 32'h80);
        bus_rd(OFF_DOUT, r); check("t4_a1", r, 32'hF0);
        bus_rd(OFF_DOUT, r); check("t4_sat", r, 32'hFF);
        bus_wr(OFF_CTRL, 32'hF);
        bus_wr(OFF_DIN, 32'h05);
        bus_rd(OFF_DOUT, r); check("t4_clr", r, 32'h05);

        // Fill with EN=0, overflow, then drain into out-FIFO
        bus_wr(OFF_CTRL, 32'h8);
        for (int i = 0; i < DEPTH + 1; i++) bus_wr(OFF_DIN, 32'(i));
        bus_rd(OFF_STATUS, r);
        check("t5_in_cnt", 32'(r[12:8]), 32'd16);
        check("t5_in_full", 32'(r[1]), 32'd1);
        check("t5_ovf", 32'(r[4]), 32'd1);
        bus_wr(OFF_CTRL, 32'h1);
        bus_rd(OFF_STATUS, r);
        check("t5_out_cnt", 32'(r[20:16]), 32'd16);
        check("t5_in_cnt0", 32'(r[12:8]), 32'd0);
        check("t5_out_full", 32'(r[3]), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            bus_rd(OFF_DOUT, r);
            check($sformatf("t5_pop%0d", i), r, 32'(i));
        end
        bus_wr(OFF_STATUS, 32'h30);

        // Random traffic against the model
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 99);
            if (k < 35) begin
                op(OFF_DIN | 8'($urandom_range(0, 3)),
                   4'($urandom_range(1, 15)), $urandom, r);
            end else if (k < 65) begin
                op(OFF_DOUT, 4'h0, 0, r);
            end else if (k < 75) begin
                r = $urandom;
                r[3] = ($urandom_range(0, 7) == 0);
                op(OFF_CTRL, 4'($urandom_range(1, 15)), r, r);
            end else if (k < 80) begin
                op(OFF_THRESH, 4'h1, $urandom, r);
            end else if (k < 85) begin
                op(OFF_STATUS, 4'h1, $urandom, r);
            end else if (k < 95) begin
                a = {6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                if (a[7:2] > 6'd4 && $urandom_range(0, 1) == 0)
                    a = {6'($urandom_range(0, 4)), a[1:0]};
                op(a, 4'h0, 0, r);
            end else begin
                a = {6'($urandom_range(5, 63)), 2'b00};
                op(a, 4'hF, $urandom, r);
            end
        end

        // Reset during a pending read with bytes in flight
        bus_wr(OFF_CTRL, 32'h1);
        bus(OFF_DIN, 4'hF, 32'h11, r);
        bus(OFF_DIN, 4'hF, 32'h22, r);
        @(negedge clk);
        valid = 1; addr = OFF_DOUT; wstrb = 0; reset = 1;
        @(posedge clk); #1;
        check("t6_no_ready", 32'(ready), 32'd0);
        @(negedge clk);
        reset = 0; valid = 0;
        @(posedge clk); #1;
        check("t6_no_ready2", 32'(ready), 32'd0);
        model_reset();
        repeat (DEPTH + 8) @(posedge clk);
        bus_rd(OFF_STATUS, r); check("t6_status", r, 32'h5);
        bus_rd(OFF_CTRL, r);   check("t6_ctrl", r, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
